// File: rtl/ro_pair_counter_if.sv
// rtl/ro_pair_counter_if.sv - RO pair measurement control/result bundle
interface ro_pair_counter_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   Start;
  logic                   RoA;
  logic                   RoB;
  logic                   RoHold;
  logic                   Busy;
  logic                   Done;
  logic                   Response;
  logic                   Tie;
  logic [COUNT_WIDTH-1:0] CountA;
  logic [COUNT_WIDTH-1:0] CountB;

  // Requester side: issues Start, supplies the ring outputs, observes results
  modport master (
    output Start, RoA, RoB,
    input  RoHold, Busy, Done, Response, Tie, CountA, CountB
  );

  // Measurement stage side
  modport slave (
    input  Start, RoA, RoB,
    output RoHold, Busy, Done, Response, Tie, CountA, CountB
  );
endinterface

// File: rtl/ro_pair_counter.sv
// rtl/ro_pair_counter.sv - RO-PUF pair measurement: settle, count edges, compare
module ro_pair_counter #(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 4096,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  ro_pair_counter_if.slave bus
);
  // One timer serves both phases, so it is sized for the longer of the two
  localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, COMPARE} state_t;

  state_t                 state;
  logic [TW-1:0]          timer;
  logic [COUNT_WIDTH-1:0] cnt_a, cnt_b;
  logic [COUNT_WIDTH-1:0] cnt_a_nxt, cnt_b_nxt;
  logic [COUNT_WIDTH-1:0] count_a, count_b;
  logic                   sync1_a, sync2_a, hist_a;
  logic                   sync1_b, sync2_b, hist_b;
  logic                   pulse_a, pulse_b;
  logic                   rohold, busy, done, response, tie;

  // Bring each ring output into the Clk domain and keep one cycle of history for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_a <= 1'b0;
      sync2_a <= 1'b0;
      hist_a  <= 1'b0;
      sync1_b <= 1'b0;
      sync2_b <= 1'b0;
      hist_b  <= 1'b0;
    end else begin
      sync1_a <= bus.RoA;
      sync2_a <= sync1_a;
      hist_a  <= sync2_a;
      sync1_b <= bus.RoB;
      sync2_b <= sync1_b;
      hist_b  <= sync2_b;
    end
  end

  assign pulse_a = sync2_a & ~hist_a;
  assign pulse_b = sync2_b & ~hist_b;

  // Candidate counter values: pulses only count inside the window, and counts stick at all-ones
  always_comb begin
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    if (state == COUNT) begin
      if (pulse_a && (cnt_a != '1)) cnt_a_nxt = cnt_a + 1'b1;
      if (pulse_b && (cnt_b != '1)) cnt_b_nxt = cnt_b + 1'b1;
    end
  end

  // Measurement sequencer; results are captured on the edge that enters COMPARE so they
  // are already on the outputs during the single Done cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      timer    <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      count_a  <= '0;
      count_b  <= '0;
      rohold   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= 1'b0;
      tie      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state  <= SETTLE;
            timer  <= SETTLE_LOAD;
            cnt_a  <= '0;
            cnt_b  <= '0;
            busy   <= 1'b1;
            rohold <= 1'b0;
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            state <= COUNT;
            timer <= WINDOW_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        COUNT: begin
          cnt_a <= cnt_a_nxt;
          cnt_b <= cnt_b_nxt;
          if (timer == '0) begin
            state    <= COMPARE;
            rohold   <= 1'b1;
            done     <= 1'b1;
            count_a  <= cnt_a_nxt;
            count_b  <= cnt_b_nxt;
            response <= (cnt_a_nxt > cnt_b_nxt);
            tie      <= (cnt_a_nxt == cnt_b_nxt);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        COMPARE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          rohold <= 1'b1;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RoHold   = rohold;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Response = response;
  assign bus.Tie      = tie;
  assign bus.CountA   = count_a;
  assign bus.CountB   = count_b;
endmodule

// File: tb/tb_ro_pair_counter.sv
// tb/tb_ro_pair_counter.sv - directed bench with cycle-level behavioural model for ro_pair_counter
module tb_ro_pair_counter;
  localparam int S0 = 4, W0 = 16, CW0 = 16;
  localparam int S1 = 4, W1 = 64, CW1 = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic roa = 1'b0, rob = 1'b0;

  always #5 Clk = ~Clk;

  ro_pair_counter_if #(.COUNT_WIDTH(CW0)) bus0 ();
  ro_pair_counter_if #(.COUNT_WIDTH(CW1)) bus1 ();

  assign bus0.Start = start0;
  assign bus0.RoA   = roa;
  assign bus0.RoB   = rob;
  assign bus1.Start = start1;
  assign bus1.RoA   = roa;
  assign bus1.RoB   = rob;

  ro_pair_counter #(.SETTLE_CYCLES(S0), .WINDOW_CYCLES(W0), .COUNT_WIDTH(CW0)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(bus0.slave));
  ro_pair_counter #(.SETTLE_CYCLES(S1), .WINDOW_CYCLES(W1), .COUNT_WIDTH(CW1)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1.slave));

  logic [1:0]  o_busy, o_done, o_hold, o_resp, o_tie;
  logic [15:0] o_ca [2];
  logic [15:0] o_cb [2];
  assign o_busy = {bus1.Busy, bus0.Busy};
  assign o_done = {bus1.Done, bus0.Done};
  assign o_hold = {bus1.RoHold, bus0.RoHold};
  assign o_resp = {bus1.Response, bus0.Response};
  assign o_tie  = {bus1.Tie, bus0.Tie};
  assign o_ca[0] = bus0.CountA;
  assign o_cb[0] = bus0.CountB;
  assign o_ca[1] = {12'b0, bus1.CountA};
  assign o_cb[1] = {12'b0, bus1.CountB};

  int nerr = 0, nchk = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit ha [0:4095];
  bit hb [0:4095];
  int sp [2] = '{S0, S1};
  int wp [2] = '{W0, W1};
  int cwp [2] = '{CW0, CW1};
  bit m_run [2];
  int m_s [2];
  bit e_busy [2], e_done [2], e_hold [2], e_resp [2], e_tie [2];
  int e_ca [2], e_cb [2];
  int done_cnt [2];

  int pa = 0, pb = 0, g = 0;
  bit lvl_a = 0, lvl_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Rising edges of a recorded ring waveform whose 2-cycle-late image lands in [lo, hi]
  function automatic int rises(input bit which, input int lo, input int hi);
    int n = 0;
    for (int r = lo - 2; r <= hi - 2; r++) begin
      if (which ? (hb[r] && !hb[r-1]) : (ha[r] && !ha[r-1])) n++;
    end
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  // Ring oscillator stand-ins: square wave of the chosen period, or a constant level
  initial forever begin
    @(negedge Clk);
    g++;
    roa = (pa > 0) ? ((g % pa) < pa / 2) : lvl_a;
    rob = (pb > 0) ? ((g % pb) < pb / 2) : lvl_b;
  end

  // Model: a run accepted in cycle s holds the rings released for s+1..s+S+W, reports in s+S+W+1
  initial forever begin
    @(posedge Clk);
    ha[cyc] = roa;
    hb[cyc] = rob;
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_run[i] = 0;
        e_ca[i] = 0; e_cb[i] = 0; e_resp[i] = 0; e_tie[i] = 0;
      end else if (!m_run[i] && ((i == 0) ? start0 : start1)) begin
        m_run[i] = 1;
        m_s[i] = cyc;
      end else if (m_run[i] && cyc == m_s[i] + sp[i] + wp[i] + 1) begin
        m_run[i] = 0;
      end
    end
    if (Reset) chk_en = 1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      e_busy[i] = m_run[i];
      e_done[i] = m_run[i] && (cyc == m_s[i] + sp[i] + wp[i] + 1);
      e_hold[i] = !(m_run[i] && cyc <= m_s[i] + sp[i] + wp[i]);
      if (e_done[i]) begin
        e_ca[i] = sat(rises(0, m_s[i] + sp[i] + 1, m_s[i] + sp[i] + wp[i]), cwp[i]);
        e_cb[i] = sat(rises(1, m_s[i] + sp[i] + 1, m_s[i] + sp[i] + wp[i]), cwp[i]);
        e_resp[i] = e_ca[i] > e_cb[i];
        e_tie[i] = e_ca[i] == e_cb[i];
      end
    end
  end

  // Every cycle, both DUTs against the model
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(e_busy[i]));
        chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(e_done[i]));
        chk($sformatf("rohold%0d", i), 32'(o_hold[i]), 32'(e_hold[i]));
        chk($sformatf("counta%0d", i), 32'(o_ca[i]), e_ca[i]);
        chk($sformatf("countb%0d", i), 32'(o_cb[i]), e_cb[i]);
        chk($sformatf("response%0d", i), 32'(o_resp[i]), 32'(e_resp[i]));
        chk($sformatf("tie%0d", i), 32'(o_tie[i]), 32'(e_tie[i]));
        if (o_done[i] === 1'b1) done_cnt[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One measurement with literal expectations; rep re-pulses Start during SETTLE and COUNT
  task automatic run(input int i, input bit rep, input int lat, input int ea, input int eb,
                     input int er, input int et, input string nm);
    int c0, d0, t;
    c0 = cyc;
    d0 = done_cnt[i];
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
    t = 0;
    while (o_done[i] !== 1'b1 && t < 300) begin
      if (i == 0) start0 = rep && ((cyc - c0 == 2) || (cyc - c0 == 8));
      tick(1);
      t++;
    end
    start0 = 1'b0;
    chk({nm, "_timeout"}, 32'(t < 300), 1);
    chk({nm, "_latency"}, cyc - c0, lat);
    chk({nm, "_counta"}, 32'(o_ca[i]), ea);
    chk({nm, "_countb"}, 32'(o_cb[i]), eb);
    chk({nm, "_response"}, 32'(o_resp[i]), er);
    chk({nm, "_tie"}, 32'(o_tie[i]), et);
    chk({nm, "_model_counta"}, e_ca[i], ea);
    chk({nm, "_model_countb"}, e_cb[i], eb);
    tick(10);
    chk({nm, "_done_pulses"}, done_cnt[i] - d0, 1);
  endtask

  initial begin
    int d0;
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(1);
    chk("rst_busy", 32'(o_busy[0]), 0);
    chk("rst_rohold", 32'(o_hold[0]), 1);
    chk("rst_counta", 32'(o_ca[0]), 0);
    chk("rst_done1", 32'(o_done[1]), 0);

    pa = 4; pb = 8; tick(12);
    run(0, 0, 21, 4, 2, 1, 0, "t1");

    pa = 8; pb = 4; tick(12);
    run(0, 0, 21, 2, 4, 0, 0, "t2");

    pa = 2; pb = 4; tick(12);
    run(1, 0, 69, 15, 15, 0, 1, "t3_sat");

    pa = 4; pb = 8; tick(12);
    d0 = done_cnt[0];
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(9);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("t4_busy", 32'(o_busy[0]), 0);
    chk("t4_rohold", 32'(o_hold[0]), 1);
    chk("t4_done", 32'(o_done[0]), 0);
    chk("t4_counta", 32'(o_ca[0]), 0);
    chk("t4_countb", 32'(o_cb[0]), 0);
    chk("t4_response", 32'(o_resp[0]), 0);
    tick(30);
    chk("t4_no_done", done_cnt[0] - d0, 0);
    run(0, 0, 21, 4, 2, 1, 0, "t4_rerun");

    tick(4);
    run(0, 1, 21, 4, 2, 1, 0, "t5_restart");

    pa = 0; pb = 0; lvl_a = 1; lvl_b = 1; tick(8);
    run(0, 0, 21, 0, 0, 0, 1, "t6_high");
    lvl_a = 0; lvl_b = 0; tick(8);
    run(0, 0, 21, 0, 0, 0, 1, "t6_low");

    tick(2);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Measurement stage directly downstream of a pair of ring oscillators in the RO-PUF.
- Releases both oscillators, waits for them to settle, then counts rising edges of each oscillator over a fixed clock window.
- Compares the two counts and produces one PUF response bit, plus the raw counts for characterisation.
- Drives each oscillator's hold input. Oscillator convention: Enable=1 freezes the ring, Enable=0 lets it run.

Parameters:
- SETTLE_CYCLES, 16: Clk cycles oscillators run before counting starts; must be ≥1.
- WINDOW_CYCLES, 4096: Clk cycles during which edges are counted; must be ≥1.
- COUNT_WIDTH, 16: width of each edge counter and of CountA/CountB.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request one measurement; sampled only in IDLE.
- RoA  in  1  oscillator A output; asynchronous to Clk.
- RoB  in  1  oscillator B output; asynchronous to Clk.
- RoHold  out  1  to Enable of both oscillators; 1 = frozen, 0 = oscillating.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse; results valid from this cycle.
- Response  out  1  1 if CountA > CountB, else 0.
- Tie  out  1  1 if CountA == CountB.
- CountA  out  COUNT_WIDTH  final saturated edge count of RoA.
- CountB  out  COUNT_WIDTH  final saturated edge count of RoB.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE, RoHold=1, Busy=0, Done=0;
  - Response=0, Tie=0, CountA=0, CountB=0;
  - internal counters, timer and all synchroniser/history flops = 0.
- Input conditioning, per RO:
  - 2-flop synchroniser followed by a history flop.
  - Edge pulse = sync2 & ~hist.
  - Supported RO frequency: no more than Clk/2 at the synchroniser input. Faster oscillators are out of scope and must be prescaled upstream.
- FSM states: IDLE, SETTLE, COUNT, COMPARE.
  - IDLE: RoHold=1. If Start=1, go to SETTLE: clear both counters, load timer, Busy=1.
  - SETTLE: RoHold=0. Stay exactly SETTLE_CYCLES cycles, then go to COUNT with the timer reloaded.
  - COUNT: RoHold=0. For exactly WINDOW_CYCLES cycles, each edge pulse increments its counter. Pulses in any other state are ignored. On exit RoHold returns to 1.
  - COMPARE: one cycle. Register CountA/CountB from the counters, Response = (A > B), Tie = (A == B). Assert Done for this one cycle. Busy=0 from the next cycle; go to IDLE.
- Latency: Start sampled at cycle 0 → Done high at cycle SETTLE_CYCLES + WINDOW_CYCLES + 1.
- Results hold stable until the next COMPARE or Reset.
- Counters saturate at 2^COUNT_WIDTH−1; they never wrap.
- Tie forces Response=0.
- Start while Busy=1 is ignored: no queueing, no restart.
- Start held high continuously starts a new run on the cycle after Done.
- Reset mid-run (any state): immediate return to IDLE with reset values. RoHold=1 from the next cycle; no Done pulse.
- Simultaneous edge pulses on A and B in one cycle: both counters increment.

Test Plan:
- Bench-generated RoA, Clk-synchronous, rising edge every 4 cycles; RoB rising edge every 8 cycles. SETTLE=4, WINDOW=16, Start at cycle 0 → Done exactly at cycle 21, CountA=4, CountB=2, Response=1, Tie=0. RoHold=0 only during cycles 1–20.
- RoA and RoB swapped relative to the first test → CountA=2, CountB=4, Response=0, Tie=0.
- COUNT_WIDTH=4, WINDOW=64, RoA period 2, RoB period 4 → CountA=15, CountB=15 (both saturated), Tie=1, Response=0.
- Reset pulsed 5 cycles into COUNT → next cycle: Busy=0, RoHold=1, all outputs 0; no Done for the aborted run. A new Start then completes normally with the first test's values.
- Start pulsed again during SETTLE and during COUNT → ignored; exactly one Done, at cycle 21.
- RoA and RoB held constant at 1, then constant at 0 → CountA=CountB=0, Tie=1, Response=0, no spurious edges counted.
